// File: rtl/lifegame_frame_scheduler.sv
// lifegame_frame_scheduler
//
// Frame-level scheduler for the Game of Life display. It sits between the
// VGA raster counters, the cell-memory display reader and the life-update
// engine. The block does three things:
//   - It decodes the 800x525 raster counts into registered sync, display
//     enable and pixel coordinates.
//   - It launches one generation update per trigger inside vertical blanking.
//   - It owns the cell-memory port select. An update still running when
//     active video begins is aborted and flagged as an overrun.
//
// Optional feature: define LIFEGAME_AUTORUN_EN to build in the frame divider.
// The divider raises a step request every FRAME_DIV frames while run=1.
// Without it, run is ignored and only step_req triggers steps.
//
// Ports
//   plk         pixel clock
//   rst_n       asynchronous reset, active-low
//   h_count     horizontal count 0..799
//   v_count     vertical count 0..524
//   run         level, enables automatic stepping (autorun build only)
//   step_req    one-cycle pulse, request a single generation step
//   step_done   one-cycle pulse from the update engine, generation finished
//   ovr_clr     clears the overrun flag
//   hsync       active-low horizontal sync
//   vsync       active-low vertical sync
//   de          display enable
//   pix_x       visible column 0..639 (0 outside the visible area)
//   pix_y       visible row 0..479 (0 outside the visible area)
//   mem_sel     cell-memory owner, 0 = display reader, 1 = updater
//   step_start  one-cycle pulse, starts the update engine
//   step_abort  one-cycle pulse, the update engine must stop
//   busy        a step is pending or in progress
//   overrun     sticky, an update ran into active video
//   gen_count   completed generations (wraps)
module lifegame_frame_scheduler #(
    parameter int FRAME_DIV = 8
) (
    input  logic        plk,
    input  logic        rst_n,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        run,
    input  logic        step_req,
    input  logic        step_done,
    input  logic        ovr_clr,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        mem_sel,
    output logic        step_start,
    output logic        step_abort,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] gen_count
);

    typedef enum logic [1:0] {IDLE, ARMED, STEP, UPDATE} state_t;

    state_t state_q, state_d;
    logic   pending_q, pending_d;
    logic   enter_step, done_ok, abort_d, start_d, memsel_d, busy_d;
    logic   div_fire;

    // Last cycle before vertical blanking / last cycle before active video.
    logic frame_tick, display_edge, de_d;
    assign frame_tick   = (h_count == 10'd799) && (v_count == 10'd524);
    assign display_edge = (h_count == 10'd799) && (v_count == 10'd44);
    assign de_d         = (h_count >= 10'd160) && (v_count >= 10'd45);

`ifdef LIFEGAME_AUTORUN_EN
    logic [7:0] div_cnt;

    always_ff @(posedge plk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= 8'd0;
        else if (!run)
            div_cnt <= 8'd0;
        else if (frame_tick)
            div_cnt <= (div_cnt == 8'(FRAME_DIV - 1)) ? 8'd0 : div_cnt + 8'd1;
    end

    assign div_fire = run && frame_tick && (div_cnt == 8'(FRAME_DIV - 1));
`else
    // No divider: the automatic trigger is tied off. FRAME_DIV is never 0,
    // so this term is constant 0.
    assign div_fire = run & (FRAME_DIV == 0);
`endif

    // State register
    always_ff @(posedge plk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pending_q) state_d = ARMED;
            ARMED:   if (frame_tick) state_d = STEP;
            STEP:    state_d = UPDATE;
            UPDATE:  if (step_done || display_edge) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. It computes the value each registered output takes
    // after the coming edge. Because mem_sel, step_start and busy are
    // derived from state_d, they line up with the state they describe.
    always_comb begin
        enter_step = (state_q == ARMED) && frame_tick;
        // A trigger that lands while already pending collapses into it.
        // Entering STEP consumes the pending trigger.
        pending_d  = (pending_q | step_req | div_fire) & ~enter_step;
        done_ok    = (state_q == UPDATE) && step_done;
        // When completion and the display edge coincide, completion wins.
        abort_d    = (state_q == UPDATE) && display_edge && !step_done;
        start_d    = (state_d == STEP);
        memsel_d   = (state_d == STEP) || (state_d == UPDATE);
        busy_d     = (state_d != IDLE) || pending_d;
    end

    // Registered outputs
    always_ff @(posedge plk or negedge rst_n) begin
        if (!rst_n) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            de         <= 1'b0;
            pix_x      <= 10'd0;
            pix_y      <= 9'd0;
            mem_sel    <= 1'b0;
            step_start <= 1'b0;
            step_abort <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            gen_count  <= 16'd0;
        end else begin
            hsync      <= !((h_count >= 10'd16) && (h_count <= 10'd111));
            vsync      <= !((v_count >= 10'd10) && (v_count <= 10'd11));
            de         <= de_d;
            pix_x      <= de_d ? (h_count - 10'd160) : 10'd0;
            pix_y      <= de_d ? 9'(v_count - 10'd45) : 9'd0;
            mem_sel    <= memsel_d;
            step_start <= start_d;
            step_abort <= abort_d;
            busy       <= busy_d;
            // A new overrun takes priority over a clear in the same cycle.
            if (abort_d)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
            if (done_ok)
                gen_count <= gen_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_lifegame_frame_scheduler.sv
module tb_lifegame_frame_scheduler;

`ifdef LIFEGAME_AUTORUN_EN
    localparam int FD = 3;
`else
    localparam int FD = 8;
`endif

    logic        plk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_count = '0;
    logic [9:0]  v_count = '0;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        step_done = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        hsync, vsync, de, mem_sel, step_start, step_abort, busy, overrun;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [15:0] gen_count;

    int errors = 0;
    int checks = 0;
    int exp_gen = 0;

    lifegame_frame_scheduler #(.FRAME_DIV(FD)) dut (
        .plk(plk), .rst_n(rst_n), .h_count(h_count), .v_count(v_count),
        .run(run), .step_req(step_req), .step_done(step_done), .ovr_clr(ovr_clr),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .mem_sel(mem_sel), .step_start(step_start), .step_abort(step_abort),
        .busy(busy), .overrun(overrun), .gen_count(gen_count)
    );

    always #5 plk = ~plk;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick;
        @(posedge plk);
        #1;
    endtask

    task automatic set_cnt(input int h, input int v);
        h_count = 10'(h);
        v_count = 10'(v);
    endtask

    task automatic adv;
        if (h_count == 10'd799) begin
            h_count = 10'd0;
            v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count = h_count + 10'd1;
        end
    endtask

    task automatic pulse_req;
        step_req = 1'b1;
        tick;
        step_req = 1'b0;
    endtask

    // Walk up to and through frame_tick. early counts step_start seen before it.
    task automatic to_frame_tick(output logic st, output int early);
        early = 0;
        for (int h = 796; h <= 799; h++) begin
            set_cnt(h, 524);
            tick;
            if (h < 799 && step_start) early++;
        end
        st = step_start;
    endtask

    // Counter starts at (0,0) in the step_start cycle; step_done in cycle d.
    task automatic serve(input int d, output int ms, output int st, output int ab);
        ms = 0; st = 0; ab = 0;
        set_cnt(0, 0);
        for (int c = 0; c <= d; c++) begin
            ms += int'(mem_sel);
            st += int'(step_start);
            ab += int'(step_abort);
            step_done = (c == d);
            tick;
            step_done = 1'b0;
            adv;
        end
    endtask

    // Reference raster decode straight from the timing rules.
    function automatic void raster_ref(input int h, input int v, output logic ehs,
                                       output logic evs, output logic ede,
                                       output int ex, output int ey);
        ehs = !(h >= 16 && h <= 111);
        evs = !(v >= 10 && v <= 11);
        ede = (h >= 160) && (v >= 45);
        ex  = ede ? h - 160 : 0;
        ey  = ede ? v - 45 : 0;
    endfunction

    task automatic test_reset;
        logic [42:0] got;
        rst_n = 1'b0;
        tick; tick;
        got = {hsync, vsync, de, pix_x, pix_y, mem_sel, step_start, step_abort,
               busy, overrun, gen_count};
        checks++;
        if (got !== {2'b11, 41'd0}) begin
            errors++;
            $display("FAIL reset_values got=%h want=%h", got, {2'b11, 41'd0});
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic check_raster(input int h, input int v);
        logic ehs, evs, ede;
        int ex, ey;
        raster_ref(h, v, ehs, evs, ede, ex, ey);
        set_cnt(h, v);
        tick;
        checks++;
        if (hsync !== ehs || vsync !== evs || de !== ede ||
            pix_x !== 10'(ex) || pix_y !== 9'(ey)) begin
            errors++;
            $display("FAIL raster (%0d,%0d) got hs=%b vs=%b de=%b x=%0d y=%0d want hs=%b vs=%b de=%b x=%0d y=%0d",
                     h, v, hsync, vsync, de, pix_x, pix_y, ehs, evs, ede, ex, ey);
        end
    endtask

    task automatic test_raster;
        int hs[8];
        int vs[8];
        hs = '{0, 15, 16, 111, 112, 159, 160, 799};
        vs = '{0, 9, 10, 11, 12, 44, 45, 524};
        foreach (hs[i]) foreach (vs[j]) check_raster(hs[i], vs[j]);
        for (int k = 0; k < 200; k++)
            check_raster(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
        // contiguous stretch across the hsync start
        for (int h = 12; h < 20; h++) check_raster(h, 100);
    endtask

    task automatic test_step_done(input int d, input string nm);
        logic st;
        int early, ms, sc, ab;
        set_cnt(300, 200);
        pulse_req;
        checks++;
        if (busy !== 1'b1 || mem_sel !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_after_req got busy=%b mem_sel=%b want 1 0", nm, busy, mem_sel);
        end
        to_frame_tick(st, early);
        checks++;
        if (st !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL %s_start_at_00 got start=%b early=%0d want 1 0", nm, st, early);
        end
        serve(d, ms, sc, ab);
        exp_gen = (exp_gen + 1) % 65536;
        checks++;
        if (ms != d + 1 || sc != 1 || ab != 0) begin
            errors++;
            $display("FAIL %s_memsel_window got ms=%0d starts=%0d aborts=%0d want %0d 1 0",
                     nm, ms, sc, ab, d + 1);
        end
        checks++;
        if (gen_count !== 16'(exp_gen) || overrun !== 1'b0 || mem_sel !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done got gen=%0d ovr=%b ms=%b busy=%b want %0d 0 0 0",
                     nm, gen_count, overrun, mem_sel, busy, exp_gen);
        end
    endtask

    task automatic test_random_steps;
        for (int k = 0; k < 4; k++)
            test_step_done(int'($urandom_range(1, 3000)), "rand_step");
    endtask

    // One aborted update; clr_at_edge raises ovr_clr at the display edge.
    task automatic abort_once(input logic clr_at_edge, input string nm);
        logic st;
        int early;
        pulse_req;
        to_frame_tick(st, early);
        set_cnt(0, 0);
        tick;
        set_cnt(798, 44);
        tick;
        checks++;
        if (mem_sel !== 1'b1 || step_abort !== 1'b0) begin
            errors++;
            $display("FAIL %s_pre_edge got ms=%b abort=%b want 1 0", nm, mem_sel, step_abort);
        end
        set_cnt(799, 44);
        ovr_clr = clr_at_edge;
        tick;
        ovr_clr = 1'b0;
        checks++;
        if (step_abort !== 1'b1 || mem_sel !== 1'b0 || overrun !== 1'b1 ||
            gen_count !== 16'(exp_gen) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_abort got abort=%b ms=%b ovr=%b gen=%0d busy=%b want 1 0 1 %0d 0",
                     nm, step_abort, mem_sel, overrun, gen_count, busy, exp_gen);
        end
        set_cnt(0, 45);
        tick;
        checks++;
        if (step_abort !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL %s_abort_pulse_len got abort=%b ovr=%b want 0 1", nm, step_abort, overrun);
        end
        ovr_clr = 1'b1;
        tick;
        ovr_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s_ovr_clr got %b want 0", nm, overrun);
        end
    endtask

    task automatic test_abort;
        abort_once(1'b0, "abort");
        abort_once(1'b1, "abort_set_wins");
    endtask

    task automatic test_done_at_edge;
        logic st;
        int early;
        pulse_req;
        to_frame_tick(st, early);
        set_cnt(0, 0);
        tick;
        set_cnt(799, 44);
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        exp_gen = (exp_gen + 1) % 65536;
        checks++;
        if (gen_count !== 16'(exp_gen) || step_abort !== 1'b0 || overrun !== 1'b0 || mem_sel !== 1'b0) begin
            errors++;
            $display("FAIL done_at_edge got gen=%0d abort=%b ovr=%b ms=%b want %0d 0 0 0",
                     gen_count, step_abort, overrun, mem_sel, exp_gen);
        end
    endtask

    task automatic test_back_to_back;
        logic st;
        int early, ms, sc, ab;
        // done outside UPDATE is ignored
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        tick;
        checks++;
        if (gen_count !== 16'(exp_gen)) begin
            errors++;
            $display("FAIL idle_done_ignored got gen=%0d want %0d", gen_count, exp_gen);
        end
        pulse_req;
        tick;
        pulse_req;
        to_frame_tick(st, early);
        set_cnt(0, 0);
        tick;
        pulse_req;
        step_done = 1'b1;
        tick;
        step_done = 1'b0;
        exp_gen = (exp_gen + 1) % 65536;
        checks++;
        if (mem_sel !== 1'b0 || busy !== 1'b1 || gen_count !== 16'(exp_gen)) begin
            errors++;
            $display("FAIL b2b_pending_kept got ms=%b busy=%b gen=%0d want 0 1 %0d",
                     mem_sel, busy, gen_count, exp_gen);
        end
        to_frame_tick(st, early);
        checks++;
        if (st !== 1'b1 || early != 0) begin
            errors++;
            $display("FAIL b2b_second_start got start=%b early=%0d want 1 0", st, early);
        end
        serve(5, ms, sc, ab);
        exp_gen = (exp_gen + 1) % 65536;
        checks++;
        if (busy !== 1'b0 || gen_count !== 16'(exp_gen)) begin
            errors++;
            $display("FAIL b2b_second_done got busy=%b gen=%0d want 0 %0d", busy, gen_count, exp_gen);
        end
        to_frame_tick(st, early);
        checks++;
        if (st !== 1'b0 || early != 0) begin
            errors++;
            $display("FAIL b2b_no_queue got start=%b early=%0d want 0 0", st, early);
        end
    endtask

    task automatic test_reset_mid_update;
        logic st;
        int early, ab;
        pulse_req;
        to_frame_tick(st, early);
        set_cnt(0, 0);
        tick;
        pulse_req;
        checks++;
        if (mem_sel !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_update got ms=%b want 1", mem_sel);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_gen = 0;
        checks++;
        if (mem_sel !== 1'b0 || busy !== 1'b0 || step_start !== 1'b0 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_async got ms=%b busy=%b start=%b gen=%0d want 0 0 0 0",
                     mem_sel, busy, step_start, gen_count);
        end
        tick;
        rst_n = 1'b1;
        ab = 0;
        for (int h = 796; h <= 799; h++) begin
            set_cnt(h, 44);
            tick;
            ab += int'(step_abort);
        end
        set_cnt(0, 45);
        tick;
        ab += int'(step_abort);
        to_frame_tick(st, early);
        checks++;
        if (ab != 0 || st !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_release got aborts=%0d start=%b busy=%b ovr=%b want 0 0 0 0",
                     ab, st, busy, overrun);
        end
    endtask

`ifdef LIFEGAME_AUTORUN_EN
    task automatic test_autorun;
        logic st, exp_st;
        int early, pulses, last, bad_gap;
        pulses = 0; last = -1; bad_gap = 0;
        for (int f = 1; f <= 13; f++) begin
            run = (f <= 12);
            to_frame_tick(st, early);
            // divider fires on every FD-th tick with run high; step on the next tick
            exp_st = (f > 1) && ((f - 1) % FD == 0) && (f - 1 <= 12);
            checks++;
            if (st !== exp_st || early != 0) begin
                errors++;
                $display("FAIL autorun_frame%0d got start=%b early=%0d want %b 0", f, st, early, exp_st);
            end
            if (st === 1'b1) begin
                if (last >= 0 && f - last != FD) bad_gap++;
                last = f;
                pulses++;
            end
            set_cnt(0, 0);
            tick;
            set_cnt(1, 0);
            step_done = st;
            tick;
            step_done = 1'b0;
            set_cnt(2, 0);
            tick;
        end
        run = 1'b0;
        checks++;
        if (pulses != 4 || bad_gap != 0) begin
            errors++;
            $display("FAIL autorun_pulses got %0d gaps_bad=%0d want 4 0", pulses, bad_gap);
        end
        exp_gen = (exp_gen + pulses) % 65536;
    endtask
`endif

    initial begin
        test_reset;
        test_raster;
        test_step_done(1000, "step_1000");
        test_random_steps;
        test_abort;
        test_done_at_edge;
        test_back_to_back;
        test_reset_mid_update;
`ifdef LIFEGAME_AUTORUN_EN
        test_autorun;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lifegame_frame_scheduler.md
# lifegame_frame_scheduler

Frame-level scheduler between the VGA horizontal/vertical counters, the cell-memory display reader and the life-update engine. It decodes the 800×525 raster counts into registered sync, display-enable and pixel coordinates. It starts one generation update per trigger inside vertical blanking and owns the cell-memory port select. If an update runs into active video, it aborts the update and flags the overrun.

## Interface
- FRAME_DIV, 8: frames per automatic generation step; legal range 1..255.
- plk  in  1  pixel clock.
- rst_n  in  1  asynchronous reset, active-low.
- h_count  in  10  horizontal count, 0..799.
- v_count  in  10  vertical count, 0..524.
- run  in  1  level; enables automatic stepping every FRAME_DIV frames.
- step_req  in  1  one-cycle pulse; requests a single generation step.
- step_done  in  1  one-cycle pulse from the update engine; generation finished.
- ovr_clr  in  1  clears overrun.
- hsync  out  1  active-low horizontal sync.
- vsync  out  1  active-low vertical sync.
- de  out  1  display enable.
- pix_x  out  10  visible column, 0..639.
- pix_y  out  9  visible row, 0..479.
- mem_sel  out  1  cell-memory owner; 0 = display reader, 1 = updater.
- step_start  out  1  one-cycle pulse; starts the update engine.
- step_abort  out  1  one-cycle pulse; the update engine must stop.
- busy  out  1  a step is pending or in progress.
- overrun  out  1  sticky; an update hit active video.
- gen_count  out  16  completed generations.

## Operation
- Raster decode:
  - hsync low for h_count 16..111.
  - vsync low for v_count 10..11.
  - de high for h_count ≥ 160 and v_count ≥ 45.
  - pix_x = h_count−160 and pix_y = v_count−45 while de; both 0 otherwise.
- frame_tick = (h_count==799 && v_count==524). It is the last cycle before the blanking window, v_count 0..44.
- display_edge = (h_count==799 && v_count==44). It is the last cycle before active video.
- pending flag:
  - Set by step_req.
  - Set by the frame divider (see Configuration).
  - Cleared on entry to STEP.
  - A second set while pending is already high is a no-op; triggers are not queued.
- FSM states IDLE, ARMED, STEP, UPDATE; reset state is IDLE.
  - IDLE: pending → ARMED.
  - ARMED: frame_tick → STEP.
  - STEP: step_start=1 and mem_sel=1 for exactly one cycle; then → UPDATE.
  - UPDATE: mem_sel=1.
    - step_done → IDLE; gen_count increments.
    - display_edge without step_done → IDLE; step_abort pulses; overrun sets; gen_count unchanged.
    - step_done and display_edge in the same cycle: done wins; no abort.
- step_done outside UPDATE is ignored.
- busy = (state != IDLE) || pending.
- gen_count wraps 65535 → 0.
- overrun clears on ovr_clr. A set and ovr_clr in the same cycle: set wins.

## Timing
- All outputs are registered. Raster outputs have 1 cycle latency from h_count/v_count.
- Reset values: hsync=1, vsync=1, de=0, pix_x=0, pix_y=0, mem_sel=0, step_start=0, step_abort=0, busy=0, overrun=0, gen_count=0.
- Reset during UPDATE: mem_sel returns to 0 immediately; no step_abort pulse; the pending flag is lost.
- step_start rises 1 cycle after frame_tick, i.e. while the counter reads (0,0).
- Budget for the update engine: 36000 cycles from step_start to display_edge.
- mem_sel falls one cycle after step_done, or one cycle after display_edge. It is always 0 while de=1.
- step_req arriving in ARMED/STEP/UPDATE sets pending. That step is then served at the next frame_tick after returning to IDLE.

## Configuration
- LIFEGAME_AUTORUN_EN defined:
  - 8-bit frame divider, reset 0, counts frame_tick while run=1.
  - At FRAME_DIV−1 on a frame_tick it sets pending and reloads to 0.
  - run=0 holds the divider at 0.
  - The armed frame is the next frame_tick, so the step occurs one frame after the divider fires.
- Not defined: the divider is absent, run is ignored, and only step_req triggers steps.

## Test plan
- Reset, free-running counter → hsync low exactly for h_count 16..111 (1 cycle late), vsync low on lines 10..11, de first high at (160,45) with pix_x=0, pix_y=0, and pix_x=639, pix_y=479 at (799,524).
- step_req at (300,200); step_done 1000 cycles after step_start → step_start one cycle at counter (0,0), mem_sel high 1001 cycles, gen_count=1, overrun=0.
- step_req; engine never answers → step_abort pulse and mem_sel fall one cycle after (799,44), overrun=1, gen_count=0; ovr_clr → overrun=0.
- step_done coincident with display_edge → gen_count increments, no step_abort, overrun=0.
- LIFEGAME_AUTORUN_EN, FRAME_DIV=3, run=1 for 12 frames → exactly 4 step_start pulses, spaced 3×420000 cycles apart.
- Assert rst_n low mid-UPDATE → mem_sel, busy, step_start all 0 immediately, gen_count=0, no abort pulse after release.
